// File: rtl/hybrid_branch_predictor_pkg.sv
// Shared encodings for the hybrid branch predictor: 2-bit counter values,
// sweep/ready FSM states and a PC increment helper.
package hybrid_branch_predictor_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  localparam logic [0:0] BP_INIT  = 1'b0;
  localparam logic [0:0] BP_READY = 1'b1;

  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/hybrid_branch_predictor_sat_counter2.sv
// Next-value logic for a 2-bit saturating counter; holds at 00 and 11.
module hybrid_branch_predictor_sat_counter2
  import hybrid_branch_predictor_pkg::*;
(
  input  logic [1:0] cur,
  input  logic       inc,
  output logic [1:0] nxt
);

  always_comb begin
    nxt = cur;
    if (inc && cur != CTR_ST)
      nxt = cur + 2'd1;
    else if (!inc && cur != CTR_SNT)
      nxt = cur - 2'd1;
  end

endmodule

// File: rtl/hybrid_branch_predictor.sv
// Bimodal + gshare + chooser direction predictor with a direct-mapped BTB.
// Lookup is combinational on old contents; tables train from the EX update port.
module hybrid_branch_predictor
  import hybrid_branch_predictor_pkg::*;
#(
  parameter int BHT_IDX_W = 6,
  parameter int BTB_IDX_W = 4,
  parameter int GHR_W     = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pred_pc,
  output logic        pred_ready,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_val,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  logic [0:0]           state;
  logic [BHT_IDX_W-1:0] sweep_idx;
  logic [GHR_W-1:0]     ghr;

  logic [1:0]       bim_tbl    [BHT_N];
  logic [1:0]       gsh_tbl    [BHT_N];
  logic [1:0]       cho_tbl    [BHT_N];
  logic             btb_valid  [BTB_N];
  logic [TAG_W-1:0] btb_tag    [BTB_N];
  logic [31:0]      btb_target [BTB_N];

  // Fetch-side lookup
  logic [BHT_IDX_W-1:0] bim_idx, gsh_idx;
  logic [BTB_IDX_W-1:0] btb_idx;
  logic [TAG_W-1:0]     lk_tag;
  logic                 use_gsh, lk_dir, lk_hit;

  assign bim_idx = pred_pc[BHT_IDX_W+1:2];
  assign gsh_idx = bim_idx ^ BHT_IDX_W'(ghr);
  assign btb_idx = pred_pc[BTB_IDX_W+1:2];
  assign lk_tag  = pred_pc[31:BTB_IDX_W+2];
  assign use_gsh = cho_tbl[bim_idx] >= CTR_WT;
  assign lk_dir  = use_gsh ? gsh_tbl[gsh_idx][1] : bim_tbl[bim_idx][1];
  assign lk_hit  = btb_valid[btb_idx] && (btb_tag[btb_idx] == lk_tag);

  assign pred_ready  = (state == BP_READY);
  assign pred_taken  = pred_ready && lk_hit && lk_dir;
  assign pred_target = pred_taken ? btb_target[btb_idx] : pc_plus4(pred_pc);

  // Update path, indexed with the history as it stood before this branch
  logic [BHT_IDX_W-1:0] u_bim_idx, u_gsh_idx;
  logic [BTB_IDX_W-1:0] u_btb_idx;
  logic [1:0]           bim_nxt, gsh_nxt, cho_nxt;
  logic                 bim_dir, gsh_dir, cho_en, gsh_ok, do_upd;

  assign u_bim_idx = upd_pc[BHT_IDX_W+1:2];
  assign u_gsh_idx = u_bim_idx ^ BHT_IDX_W'(ghr);
  assign u_btb_idx = upd_pc[BTB_IDX_W+1:2];
  assign bim_dir   = bim_tbl[u_bim_idx][1];
  assign gsh_dir   = gsh_tbl[u_gsh_idx][1];
  assign cho_en    = bim_dir != gsh_dir;
  assign gsh_ok    = gsh_dir == upd_taken;
  assign do_upd    = (state == BP_READY) && upd_val;

  hybrid_branch_predictor_sat_counter2 u_bim_ctr (
    .cur(bim_tbl[u_bim_idx]), .inc(upd_taken), .nxt(bim_nxt)
  );
  hybrid_branch_predictor_sat_counter2 u_gsh_ctr (
    .cur(gsh_tbl[u_gsh_idx]), .inc(upd_taken), .nxt(gsh_nxt)
  );
  hybrid_branch_predictor_sat_counter2 u_cho_ctr (
    .cur(cho_tbl[u_bim_idx]), .inc(gsh_ok), .nxt(cho_nxt)
  );

  // Sweep FSM and non-speculative global history
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= BP_INIT;
      sweep_idx <= '0;
      ghr       <= '0;
    end else if (state == BP_INIT) begin
      sweep_idx <= sweep_idx + BHT_IDX_W'(1);
      if (sweep_idx == '1)
        state <= BP_READY;
    end else if (upd_val) begin
      ghr <= {ghr[GHR_W-2:0], upd_taken};
    end
  end

  // Table storage: cleared one entry per cycle during the sweep, trained afterwards
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == BP_INIT) begin
        bim_tbl[sweep_idx] <= CTR_WNT;
        gsh_tbl[sweep_idx] <= CTR_WNT;
        cho_tbl[sweep_idx] <= CTR_WNT;
        if (32'(sweep_idx) < 32'(BTB_N))
          btb_valid[sweep_idx[BTB_IDX_W-1:0]] <= 1'b0;
      end else if (do_upd) begin
        bim_tbl[u_bim_idx] <= bim_nxt;
        gsh_tbl[u_gsh_idx] <= gsh_nxt;
        if (cho_en)
          cho_tbl[u_bim_idx] <= cho_nxt;
        if (upd_taken) begin
          btb_valid[u_btb_idx]  <= 1'b1;
          btb_tag[u_btb_idx]    <= upd_pc[31:BTB_IDX_W+2];
          btb_target[u_btb_idx] <= upd_target;
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{pred_pc[1:0], upd_pc[1:0]};

endmodule
